// File: rtl/pool_sched_pkg.sv
// -----------------------------------------------------------------------------
// pool_sched_pkg
//   Shared defaults and helpers for the 2x2 max-pool scheduler.
//   Provides the codebase-wide default macros (`POOL_IN_SIZE, `OF_BW, `POOL_K)
//   when no project defines header has set them already.
//   Optional build macro consumed by pool_sched: POOL_RELU_EN.
// -----------------------------------------------------------------------------
`ifndef POOL_IN_SIZE
`define POOL_IN_SIZE 8
`endif
`ifndef OF_BW
`define OF_BW 8
`endif
`ifndef POOL_K
`define POOL_K 2
`endif

package pool_sched_pkg;

    // Pooling window edge; the row buffer holds one entry per window column.
    localparam int unsigned POOL_K_DEF = `POOL_K;

    // True when a zero-based index sits on the last position of an n-long axis.
    function automatic logic is_last(input int unsigned idx, input int unsigned n);
        return (idx == n - 1);
    endfunction

endpackage

// File: rtl/pool_cmp2.sv
// -----------------------------------------------------------------------------
// pool_cmp2
//   Combinational signed two-input maximum.
//   Ports:
//     a, b : signed BW-bit operands
//     y    : larger of a and b (either operand on a tie, value identical)
// -----------------------------------------------------------------------------
module pool_cmp2 #(
    parameter int BW = 8
) (
    input  logic signed [BW-1:0] a,
    input  logic signed [BW-1:0] b,
    output logic signed [BW-1:0] y
);

    always_comb begin
        y = (a > b) ? a : b;
    end

endmodule

// File: rtl/pool_sched.sv
// -----------------------------------------------------------------------------
// pool_sched
//   Streaming 2x2 stride-2 signed max-pool over an IN_SIZE x IN_SIZE frame.
//   Even rows pre-reduce column pairs into a row buffer; odd rows finish the
//   window and load the output register (one cycle after the accepting edge).
//   Build option: define POOL_RELU_EN to clamp negative results to zero.
//   Ports:
//     clk, reset_n          : clock, asynchronous active-low reset
//     i_start               : arm one frame (sampled in IDLE only)
//     i_in_valid/o_in_ready : input pixel handshake, i_in_pix raster order
//     o_ot_valid/i_ot_ready : pooled pixel handshake, o_ot_pix raster order
//     o_busy                : frame in progress (RUN or DRAIN)
//     o_done                : one-cycle pulse as the frame completes
// -----------------------------------------------------------------------------
module pool_sched
    import pool_sched_pkg::*;
#(
    parameter int IN_SIZE = `POOL_IN_SIZE,
    parameter int BW      = `OF_BW
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_start,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic signed [BW-1:0] i_in_pix,
    output logic                 o_ot_valid,
    input  logic                 i_ot_ready,
    output logic signed [BW-1:0] o_ot_pix,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int CW    = (IN_SIZE > 2) ? $clog2(IN_SIZE) : 1;
    localparam int DEPTH = IN_SIZE / POOL_K_DEF;
    localparam int BI    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         row, col;
    logic [BI-1:0]         buf_idx;
    logic                  accept, load, col_last, row_last;
    logic signed [BW-1:0]  held, h_max, v_max, pooled;
    logic signed [BW-1:0]  ot_pix;
    logic                  ot_valid;
    logic signed [BW-1:0]  rowbuf [DEPTH];

    assign buf_idx  = BI'(col >> 1);
    assign col_last = is_last(32'(col), IN_SIZE);
    assign row_last = is_last(32'(row), IN_SIZE);
    assign accept   = i_in_valid && o_in_ready;
    // Window completes on the odd-column pixel of an odd row.
    assign load     = accept && row[0] && col[0];

    // Horizontal pair reduction, then vertical against the buffered pair.
    pool_cmp2 #(.BW(BW)) u_cmp_h (
        .a (held),
        .b (i_in_pix),
        .y (h_max)
    );

    pool_cmp2 #(.BW(BW)) u_cmp_v (
        .a (rowbuf[buf_idx]),
        .b (h_max),
        .y (v_max)
    );

`ifdef POOL_RELU_EN
    assign pooled = v_max[BW-1] ? '0 : v_max;
`else
    assign pooled = v_max;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (i_start) state_nx = S_RUN;
            S_RUN:   if (accept && col_last && row_last) state_nx = S_DRAIN;
            S_DRAIN: if (!ot_valid) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_in_ready = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        case (state)
            S_RUN: begin
                o_busy     = 1'b1;
                // Stall input only when a result is stuck in the output register.
                o_in_ready = !(ot_valid && !i_ot_ready);
            end
            S_DRAIN: begin
                o_busy = 1'b1;
                o_done = !ot_valid;
            end
            default: ;
        endcase
    end

    // ---------------- raster counters ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row <= '0;
            col <= '0;
        end else if (state == S_IDLE && i_start) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // ---------------- datapath storage (no reset needed) ----------------
    always_ff @(posedge clk) begin
        if (accept && !col[0]) begin
            held <= i_in_pix;
        end
        if (accept && !row[0] && col[0]) begin
            rowbuf[buf_idx] <= h_max;
        end
    end

    // ---------------- output register ----------------
    // A load may coincide with consumption; the load wins so the stream
    // sustains one result per cycle without a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ot_valid <= 1'b0;
            ot_pix   <= '0;
        end else if (load) begin
            ot_valid <= 1'b1;
            ot_pix   <= pooled;
        end else if (ot_valid && i_ot_ready) begin
            ot_valid <= 1'b0;
        end
    end

    assign o_ot_valid = ot_valid;
    assign o_ot_pix   = ot_pix;

endmodule

// File: tb/tb_pool_sched.sv
// -----------------------------------------------------------------------------
// tb_pool_sched
//   Directed bench for pool_sched at IN_SIZE=4, BW=8. Frame vectors hold the
//   16 input pixels and the four hand-computed pooled results; multi-cycle
//   corners (mid-frame reset, input valid while idle) are written out by hand.
// -----------------------------------------------------------------------------
module tb_pool_sched;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              i_start;
    logic              i_in_valid;
    logic              o_in_ready;
    logic signed [7:0] i_in_pix;
    logic              o_ot_valid;
    logic              i_ot_ready;
    logic signed [7:0] o_ot_pix;
    logic              o_busy;
    logic              o_done;

    int n_checks = 0;
    int n_errors = 0;

    pool_sched #(.IN_SIZE(4), .BW(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_start    (i_start),
        .i_in_valid (i_in_valid),
        .o_in_ready (o_in_ready),
        .i_in_pix   (i_in_pix),
        .o_ot_valid (o_ot_valid),
        .i_ot_ready (i_ot_ready),
        .o_ot_pix   (o_ot_pix),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0][7:0] px;
        logic [3:0][7:0]  ex;     // raw signed max, before optional clamp
        int               stall;  // cycles of i_ot_ready=0 after first result
        bit               hold;   // keep i_start high during RUN
    } vec_t;

    vec_t vecs[5];

    function automatic void chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endfunction

    function automatic int expect_pix(input logic [7:0] raw);
        int v;
        v = int'($signed(raw));
`ifdef POOL_RELU_EN
        if (v < 0) v = 0;
`endif
        return v;
    endfunction

    task automatic run_frame(input int v, input logic [15:0][7:0] px,
                             input logic [3:0][7:0] ex, input int stall, input bit hold);
        int pi = 0;
        int oi = 0;
        int cyc = 0;
        int stall_left = 0;
        int last_cons = -10;
        int done_cnt = 0;
        bit stall_used = 0;
        bit acc;
        bit fin = 0;
        @(posedge clk); #1;
        i_start = 1'b1; i_in_valid = 1'b0; i_ot_ready = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk($sformatf("v%0d busy_after_start", v), int'(o_busy), 1);
        while (!fin && cyc < 300) begin
            if (stall > 0 && !stall_used && o_ot_valid) begin
                stall_left = stall;
                stall_used = 1'b1;
            end
            i_ot_ready = (stall_left == 0);
            i_in_valid = (pi < 16);
            i_in_pix   = (pi < 16) ? px[pi] : 8'sd0;
            i_start    = hold && (pi > 0) && (pi < 16);
            @(negedge clk);
            if (stall_left > 0) begin
                chk($sformatf("v%0d stall_pix", v), int'(o_ot_pix), expect_pix(ex[0]));
                chk($sformatf("v%0d stall_in_ready", v), int'(o_in_ready), 0);
                stall_left--;
            end
            acc = i_in_valid && o_in_ready;
            if (o_ot_valid && i_ot_ready) begin
                if (oi < 4)
                    chk($sformatf("v%0d out%0d", v, oi), int'(o_ot_pix), expect_pix(ex[oi]));
                else
                    chk($sformatf("v%0d extra_output", v), oi, 3);
                oi++;
                last_cons = cyc;
            end
            if (o_done) begin
                done_cnt++;
                chk($sformatf("v%0d done_latency", v), cyc - last_cons, 1);
                fin = 1'b1;
            end
            @(posedge clk); #1;
            if (acc) pi++;
            cyc++;
        end
        if (!fin) chk($sformatf("v%0d timeout_no_done", v), 0, 1);
        i_start = 1'b0; i_in_valid = 1'b0; i_ot_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (o_done) done_cnt++;
            chk($sformatf("v%0d idle_busy", v), int'(o_busy), 0);
        end
        chk($sformatf("v%0d done_pulses", v), done_cnt, 1);
        chk($sformatf("v%0d out_count", v), oi, 4);
        chk($sformatf("v%0d pixels_taken", v), pi, 16);
    endtask

    initial begin
        int mix[16] = '{-1, -128, 3, -4, -5, -6, -7, 2, 127, -128, -1, -1, 0, 0, -100, -2};

        // ramp 0..15 -> 5,7,13,15
        for (int j = 0; j < 16; j++) vecs[0].px[j] = 8'(j);
        vecs[0].ex = {8'd15, 8'd13, 8'd7, 8'd5};
        vecs[0].stall = 0; vecs[0].hold = 0;
        // all -8, pixel 10 = -3 -> -8,-8,-8,-3
        for (int j = 0; j < 16; j++) vecs[1].px[j] = (j == 10) ? 8'hFD : 8'hF8;
        vecs[1].ex = {8'hFD, 8'hF8, 8'hF8, 8'hF8};
        vecs[1].stall = 0; vecs[1].hold = 0;
        // ramp with 5-cycle backpressure on first result
        vecs[2].px = vecs[0].px;
        vecs[2].ex = vecs[0].ex;
        vecs[2].stall = 5; vecs[2].hold = 0;
        // descending 15..0 with i_start held during RUN -> 15,13,7,5
        for (int j = 0; j < 16; j++) vecs[3].px[j] = 8'(15 - j);
        vecs[3].ex = {8'd5, 8'd7, 8'd13, 8'd15};
        vecs[3].stall = 0; vecs[3].hold = 1;
        // signed extremes -> -1,3,127,-1
        for (int j = 0; j < 16; j++) vecs[4].px[j] = 8'(mix[j]);
        vecs[4].ex = {8'hFF, 8'd127, 8'd3, 8'hFF};
        vecs[4].stall = 2; vecs[4].hold = 0;

        reset_n = 1'b0; i_start = 1'b0; i_in_valid = 1'b0;
        i_in_pix = '0; i_ot_ready = 1'b1;
        #12;
        chk("rst_in_ready", int'(o_in_ready), 0);
        chk("rst_ot_valid", int'(o_ot_valid), 0);
        chk("rst_ot_pix",   int'(o_ot_pix), 0);
        chk("rst_busy",     int'(o_busy), 0);
        chk("rst_done",     int'(o_done), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int v = 0; v < 5; v++)
            run_frame(v, vecs[v].px, vecs[v].ex, vecs[v].stall, vecs[v].hold);

        // i_in_valid while IDLE: nothing accepted, nothing starts
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            i_in_valid = 1'b1; i_in_pix = 8'sd99;
            @(negedge clk);
            chk("idle_in_ready", int'(o_in_ready), 0);
            chk("idle_busy",     int'(o_busy), 0);
            chk("idle_ot_valid", int'(o_ot_valid), 0);
        end
        i_in_valid = 1'b0;

        // mid-frame reset after pixel 6, then a clean frame
        begin
            int pi = 0;
            int cyc = 0;
            bit acc;
            @(posedge clk); #1;
            i_start = 1'b1;
            @(posedge clk); #1;
            i_start = 1'b0;
            while (pi < 7 && cyc < 50) begin
                i_in_valid = 1'b1; i_in_pix = 8'(pi);
                @(negedge clk);
                acc = o_in_ready;
                @(posedge clk); #1;
                if (acc) pi++;
                cyc++;
            end
            chk("pre_reset_pixels", pi, 7);
            i_in_valid = 1'b0;
            #2;
            reset_n = 1'b0;
            #1;
            chk("midrst_in_ready", int'(o_in_ready), 0);
            chk("midrst_ot_valid", int'(o_ot_valid), 0);
            chk("midrst_ot_pix",   int'(o_ot_pix), 0);
            chk("midrst_busy",     int'(o_busy), 0);
            chk("midrst_done",     int'(o_done), 0);
            @(posedge clk); #1;
            reset_n = 1'b1;
            @(negedge clk);
            chk("post_reset_idle", int'(o_busy), 0);
        end
        run_frame(5, vecs[0].px, vecs[0].ex, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pool_sched.md
POOL_SCHED -- requirements
Module: pool_sched

Interface
REQ-001 SHALL have parameter IN_SIZE, default `POOL_IN_SIZE, input frame width and height in pixels; must be even and at least 2.
REQ-002 SHALL have parameter BW, default `OF_BW, signed pixel width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port i_start, input, 1 bit: arms one frame; sampled only in IDLE.
REQ-006 SHALL have port i_in_valid, input, 1 bit: input pixel valid.
REQ-007 SHALL have port o_in_ready, output, 1 bit: pixel accepted when i_in_valid && o_in_ready.
REQ-008 SHALL have port i_in_pix, input, BW bits: signed pixel, raster order, row-major.
REQ-009 SHALL have port o_ot_valid, output, 1 bit: pooled pixel valid.
REQ-010 SHALL have port i_ot_ready, input, 1 bit: pooled pixel consumed when o_ot_valid && i_ot_ready.
REQ-011 SHALL have port o_ot_pix, output, BW bits: signed 2x2 max, raster order, (IN_SIZE/2)^2 per frame.
REQ-012 SHALL have port o_busy, output, 1 bit: high in RUN and DRAIN.
REQ-013 SHALL have port o_done, output, 1 bit: one-cycle pulse on frame completion.

Function
REQ-014 SHALL implement FSM IDLE, RUN, DRAIN: IDLE->RUN on i_start; RUN->DRAIN on acceptance of pixel (IN_SIZE-1, IN_SIZE-1); DRAIN->IDLE when no pooled pixel is held; o_done pulses in the cycle DRAIN->IDLE is taken.
REQ-015 SHALL keep o_in_ready=0 outside RUN; in RUN, o_in_ready = !(o_ot_valid && !i_ot_ready).
REQ-016 SHALL track row and column counters, advanced only on accepted pixels; column wraps at IN_SIZE-1 to 0 and increments row; both clear on entering RUN.
REQ-017 SHALL, on even rows, hold the accepted even-column pixel and, on the odd-column pixel, write max(held, current) to row-buffer entry col/2 (IN_SIZE/2 entries x BW).
REQ-018 SHALL, on odd rows at odd column, form max(rowbuf[col/2], held, current) and load it into the output register, setting o_ot_valid in the next cycle (one-cycle latency from the accepting edge).
REQ-019 SHALL compare all values as signed two's complement; ties select either operand (value identical).
REQ-020 SHALL hold o_ot_pix and o_ot_valid stable while i_ot_ready=0; clear o_ot_valid on consumption unless a new result loads in the same cycle.
REQ-021 SHALL support simultaneous consume and load in one cycle without a bubble (sustained one pixel per cycle).
REQ-022 SHALL ignore i_start outside IDLE and ignore i_in_valid outside RUN.

Reset
REQ-023 SHALL, on reset_n low, asynchronously force state IDLE, counters 0, o_ot_valid=0, o_ot_pix=0, o_in_ready=0, o_busy=0, o_done=0; row buffer contents need not be reset.
REQ-024 SHALL, on reset mid-frame, discard the partial frame; the next frame requires a fresh i_start.

Configuration
REQ-025 SHALL, with `POOL_RELU_EN defined, clamp each pooled result below zero to 0 before the output register; without it, pass the signed max unchanged; latency is identical in both builds.

Structure
REQ-026 SHALL take IN_SIZE/BW defaults from the shared defines header (`POOL_IN_SIZE, `OF_BW, `POOL_K); FSM state encoding is a localparam set inside the module.
REQ-027 SHALL instantiate one sub-module pool_cmp2, a combinational signed two-input max of BW bits, used for the horizontal and vertical reductions.

Verification
REQ-028 SHALL cover IN_SIZE=4, pixels 0..15 raster, i_ot_ready=1 -> outputs 5,7,13,15, o_done one pulse after the final consumption.
REQ-029 SHALL cover IN_SIZE=4, all pixels -8 except pixel 10 = -3 -> outputs -8,-8,-8,-3 (RELU build: 0,0,0,0).
REQ-030 SHALL cover backpressure: i_ot_ready=0 for 5 cycles after the first result -> o_ot_pix held at 5, o_in_ready low while full, no data lost, sequence unchanged.
REQ-031 SHALL cover reset_n pulsed low after pixel 6 of a frame -> all outputs 0 immediately; the next frame 0..15 after i_start yields 5,7,13,15.
REQ-032 SHALL cover i_start asserted during RUN and i_in_valid asserted in IDLE -> no state change and no pixel accepted.
